spike_fifo_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port spike event FIFO between N_NEURONS Poisson neuron outputs in the neuron array. It captures single-cycle spike pulses into a pending register. It serializes them, one per cycle, as address-event words of the form {timestamp, neuron address} onto the FIFO write port. It honours the FIFO full flag and counts spikes lost to collisions.

---
 rtl/spike_fifo_arbiter.sv | 97 +++++++++
 tb/tb_spike_fifo_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_fifo_arbiter.sv
// Purpose: round-robin arbiter serialising neuron spike pulses into {ts, addr} words for a shared event FIFO.
// Latency: a spike captured at edge k raises fifo_wr during cycle k+1 if it wins and the FIFO has room.
// Backpressure: fifo_full or en low stalls grants; pending bits hold, and repeat spikes on held bits count as drops.
//
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   spike_in[N_NEURONS]   one-cycle spike pulses, bit i = neuron i
//   tick                  time-step strobe, advances the timestamp
//   en                    grant enable (capture continues while low)
//   fifo_full             FIFO full flag, used combinationally
//   fifo_wr, fifo_data    FIFO write strobe and {ts, address} event word
//   busy                  any spike pending
//   drop_cnt              saturating count of spikes lost to collisions
module spike_fifo_arbiter #(
    parameter int N_NEURONS = 16,
    parameter int ADDR_W    = 4,
    parameter int TS_W      = 12,
    parameter int CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_NEURONS-1:0]   spike_in,
    input  logic                   tick,
    input  logic                   en,
    input  logic                   fifo_full,
    output logic                   fifo_wr,
    output logic [TS_W+ADDR_W-1:0] fifo_data,
    output logic                   busy,
    output logic [CNT_W-1:0]       drop_cnt
);

    // Sum width wide enough for drop_cnt plus a full popcount without overflow.
    localparam int SUM_W = ((CNT_W > ADDR_W + 1) ? CNT_W : ADDR_W + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N_NEURONS-1:0] pending;
    logic [ADDR_W-1:0]    rr_ptr;
    logic [TS_W-1:0]      ts;

    logic [ADDR_W-1:0]    g;
    logic [ADDR_W-1:0]    idx;
    logic                 grant;
    logic [N_NEURONS-1:0] grant_mask;
    logic [N_NEURONS-1:0] drops;
    logic [ADDR_W:0]      drop_pop;
    logic [SUM_W-1:0]     drop_sum;
    logic [CNT_W-1:0]     drop_nxt;

    always_comb begin
        g          = '0;
        idx        = '0;
        grant_mask = '0;
        drop_pop   = '0;
        // Scan from the farthest offset down to zero so the set bit closest
        // to rr_ptr (in circular order) is the last assignment and wins.
        for (int k = N_NEURONS - 1; k >= 0; k--) begin
            idx = rr_ptr + ADDR_W'(k);
            if (pending[idx]) begin
                g = idx;
            end
        end
        grant = en & ~fifo_full & (|pending);
        if (grant) begin
            grant_mask = {{(N_NEURONS-1){1'b0}}, 1'b1} << g;
        end
        // A spike on a bit being granted this edge re-arms it instead of dropping.
        drops = spike_in & pending & ~grant_mask;
        for (int i = 0; i < N_NEURONS; i++) begin
            drop_pop = drop_pop + (ADDR_W+1)'(drops[i]);
        end
        drop_sum = SUM_W'(drop_cnt) + SUM_W'(drop_pop);
        drop_nxt = (drop_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : drop_sum[CNT_W-1:0];
    end

    assign fifo_wr   = grant;
    assign fifo_data = grant ? {ts, g} : '0;
    assign busy      = |pending;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= '0;
            rr_ptr   <= '0;
            ts       <= '0;
            drop_cnt <= '0;
        end else begin
            pending  <= (pending & ~grant_mask) | spike_in;
            drop_cnt <= drop_nxt;
            if (grant) begin
                rr_ptr <= g + ADDR_W'(1);
            end
            if (tick) begin
                ts <= ts + TS_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_spike_fifo_arbiter.sv
// Purpose: directed bench for spike_fifo_arbiter with a behavioural reference model.
// Latency: model outputs are compared on every falling edge; literal checks pin key cases.
// Backpressure: exercised with fifo_full held high and en low.
module tb_spike_fifo_arbiter;

    localparam int N    = 16;
    localparam int AW   = 4;
    localparam int TW   = 12;
    localparam int CW   = 8;
    localparam int TMOD = 1 << TW;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          reset_n;
    logic [N-1:0]  spike_in;
    logic          tick;
    logic          en;
    logic          fifo_full;
    logic          fifo_wr;
    logic [TW+AW-1:0] fifo_data;
    logic          busy;
    logic [CW-1:0] drop_cnt;

    int total;
    int bad;

    spike_fifo_arbiter #(
        .N_NEURONS(N), .ADDR_W(AW), .TS_W(TW), .CNT_W(CW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .spike_in  (spike_in),
        .tick      (tick),
        .en        (en),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_data (fifo_data),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit m_pend[N];
    int m_rr;
    int m_ts;
    int m_drop;

    function automatic int m_winner();
        for (int off = 0; off < N; off++) begin
            if (m_pend[(m_rr + off) % N]) return (m_rr + off) % N;
        end
        return -1;
    endfunction

    function automatic bit m_any();
        for (int i = 0; i < N; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
            m_rr = 0; m_ts = 0; m_drop = 0;
        end else begin
            int w;
            bit gr;
            int nd;
            w  = m_winner();
            gr = en && !fifo_full && (w >= 0);
            nd = 0;
            for (int i = 0; i < N; i++) begin
                bit taken;
                taken = gr && (w == i);
                if (spike_in[i] && m_pend[i] && !taken) nd++;
                m_pend[i] = (m_pend[i] && !taken) || spike_in[i];
            end
            if (gr) m_rr = (w + 1) % N;
            if (tick) m_ts = (m_ts + 1) % TMOD;
            m_drop = (m_drop + nd > CMAX) ? CMAX : m_drop + nd;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int w;
        bit gr;
        int e_data;
        w      = m_winner();
        gr     = en && !fifo_full && (w >= 0);
        e_data = gr ? ((m_ts << AW) | w) : 0;
        total++;
        if (fifo_wr !== gr) begin
            bad++;
            $display("FAIL model fifo_wr t=%0t got=%0b want=%0b", $time, fifo_wr, gr);
        end
        total++;
        if (fifo_data !== (TW+AW)'(e_data)) begin
            bad++;
            $display("FAIL model fifo_data t=%0t got=%h want=%h", $time, fifo_data, e_data);
        end
        total++;
        if (busy !== m_any()) begin
            bad++;
            $display("FAIL model busy t=%0t got=%0b want=%0b", $time, busy, m_any());
        end
        total++;
        if (drop_cnt !== CW'(m_drop)) begin
            bad++;
            $display("FAIL model drop_cnt t=%0t got=%0d want=%0d", $time, drop_cnt, m_drop);
        end
    end

    // ---------------- helpers ----------------
    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Drive inputs for the current cycle; they are sampled on the next rising edge.
    task automatic set_in(input logic [N-1:0] sp, input logic tk, input logic e, input logic ff);
        spike_in  = sp;
        tick      = tk;
        en        = e;
        fifo_full = ff;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int writes;
        total = 0;
        bad   = 0;
        reset_n = 1'b0;
        set_in('0, 1'b0, 1'b1, 1'b0);
        next_cycle();
        next_cycle();
        lit("reset_fifo_wr",   32'(fifo_wr),   32'd0);
        lit("reset_fifo_data", 32'(fifo_data), 32'd0);
        lit("reset_busy",      32'(busy),      32'd0);
        lit("reset_drop_cnt",  32'(drop_cnt),  32'd0);
        reset_n = 1'b1;
        next_cycle();

        // Single event: ts=3, neuron 4.
        for (int i = 0; i < 3; i++) begin
            set_in('0, 1'b1, 1'b1, 1'b0);
            next_cycle();
        end
        set_in(16'h0010, 1'b0, 1'b1, 1'b0);
        next_cycle();
        set_in('0, 1'b0, 1'b1, 1'b0);
        lit("single_wr",   32'(fifo_wr),   32'd1);
        lit("single_data", 32'(fifo_data), 32'h0034);
        next_cycle();
        lit("single_busy_clear", 32'(busy), 32'd0);

        // Round robin from rr_ptr=5: grants 5, 15, 0.
        set_in(16'h8021, 1'b0, 1'b1, 1'b0);
        next_cycle();
        set_in('0, 1'b0, 1'b1, 1'b0);
        lit("rr_first",  32'(fifo_data), 32'h0035);
        next_cycle();
        lit("rr_second", 32'(fifo_data), 32'h003F);
        next_cycle();
        lit("rr_third",  32'(fifo_data), 32'h0030);
        next_cycle();
        lit("rr_idle",   32'(fifo_wr),   32'd0);

        // Backpressure: four pending, FIFO full for 10 cycles.
        set_in(16'h0F00, 1'b0, 1'b1, 1'b0);
        next_cycle();
        for (int i = 0; i < 10; i++) begin
            set_in('0, 1'b0, 1'b1, 1'b1);
            lit("bp_no_write", 32'(fifo_wr), 32'd0);
            lit("bp_busy",     32'(busy),    32'd1);
            next_cycle();
        end
        writes = 0;
        for (int i = 0; i < 6; i++) begin
            set_in('0, 1'b0, 1'b1, 1'b0);
            if (fifo_wr) writes++;
            next_cycle();
        end
        lit("bp_write_count", 32'(writes),   32'd4);
        lit("bp_no_drop",     32'(drop_cnt), 32'd0);

        // Drop while disabled, then re-arm on the granted edge.
        set_in(16'h0004, 1'b0, 1'b0, 1'b0);
        next_cycle();
        set_in(16'h0004, 1'b0, 1'b0, 1'b0);
        next_cycle();
        set_in(16'h0004, 1'b0, 1'b1, 1'b0);
        lit("drop_one",     32'(drop_cnt),  32'd1);
        lit("rearm_grant",  32'(fifo_data), 32'h0032);
        next_cycle();
        set_in('0, 1'b0, 1'b1, 1'b0);
        lit("rearm_no_drop", 32'(drop_cnt),  32'd1);
        lit("rearm_second",  32'(fifo_data), 32'h0032);
        next_cycle();

        // Saturation: all bits re-spiking with grants disabled.
        for (int i = 0; i < 20; i++) begin
            set_in('1, 1'b0, 1'b0, 1'b0);
            next_cycle();
        end
        set_in('0, 1'b0, 1'b0, 1'b0);
        lit("drop_saturated", 32'(drop_cnt), 32'd255);

        // 4093 more ticks bring ts from 3 to 4096, i.e. wrap to 0.
        for (int i = 0; i < 4093; i++) begin
            set_in('0, 1'b1, 1'b0, 1'b0);
            next_cycle();
        end
        set_in('0, 1'b0, 1'b1, 1'b0);
        lit("ts_wrap_data", 32'(fifo_data), 32'h0003);
        lit("drop_holds",   32'(drop_cnt),  32'd255);
        next_cycle();

        // Asynchronous reset between edges with many bits pending.
        set_in('0, 1'b0, 1'b1, 1'b0);
        lit("pre_reset_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        lit("areset_fifo_wr",   32'(fifo_wr),   32'd0);
        lit("areset_fifo_data", 32'(fifo_data), 32'd0);
        lit("areset_busy",      32'(busy),      32'd0);
        lit("areset_drop_cnt",  32'(drop_cnt),  32'd0);
        next_cycle();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in('0, 1'b0, 1'b1, 1'b0);
            lit("post_reset_idle", 32'(fifo_wr), 32'd0);
            next_cycle();
        end
        set_in(16'h0080, 1'b0, 1'b1, 1'b0);
        next_cycle();
        set_in('0, 1'b0, 1'b1, 1'b0);
        lit("post_reset_event", 32'(fifo_data), 32'h0007);
        next_cycle();
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
